// File: rtl/buaa_pkg.sv
// Shared constants for the BUAA scrolling seven-segment display: glyph codes,
// mode encodings and active-low segment patterns (bit0 = a ... bit6 = g).
package buaa_pkg;

   localparam int unsigned GLY_W = 5;
   localparam int unsigned SEG_W = 7;

   localparam logic [GLY_W-1:0] GLY_A     = 5'd10;
   localparam logic [GLY_W-1:0] GLY_B     = 5'd11;
   localparam logic [GLY_W-1:0] GLY_C     = 5'd12;
   localparam logic [GLY_W-1:0] GLY_D     = 5'd13;
   localparam logic [GLY_W-1:0] GLY_E     = 5'd14;
   localparam logic [GLY_W-1:0] GLY_F     = 5'd15;
   localparam logic [GLY_W-1:0] GLY_U     = 5'd16;
   localparam logic [GLY_W-1:0] GLY_H     = 5'd17;
   localparam logic [GLY_W-1:0] GLY_L     = 5'd18;
   localparam logic [GLY_W-1:0] GLY_P     = 5'd19;
   localparam logic [GLY_W-1:0] GLY_DASH  = 5'd20;
   localparam logic [GLY_W-1:0] GLY_BLANK = 5'd31;

   localparam logic [1:0] MODE_STATIC = 2'b00;
   localparam logic [1:0] MODE_LEFT   = 2'b01;
   localparam logic [1:0] MODE_RIGHT  = 2'b10;
   localparam logic [1:0] MODE_BLINK  = 2'b11;

   localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
   localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
   localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
   localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
   localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
   localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;
   localparam logic [SEG_W-1:0] SEG_U     = 7'h41;
   localparam logic [SEG_W-1:0] SEG_H     = 7'h09;
   localparam logic [SEG_W-1:0] SEG_L     = 7'h47;
   localparam logic [SEG_W-1:0] SEG_P     = 7'h0C;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational glyph-code to active-low seven-segment pattern decoder.
module seg7_glyph
   import buaa_pkg::*;
(
   input  logic [4:0] code_i,
   output logic [6:0] seg_c_o
);

   always_comb begin
      seg_c_o = SEG_BLANK;
      case (code_i)
         5'd0:     seg_c_o = SEG_0;
         5'd1:     seg_c_o = SEG_1;
         5'd2:     seg_c_o = SEG_2;
         5'd3:     seg_c_o = SEG_3;
         5'd4:     seg_c_o = SEG_4;
         5'd5:     seg_c_o = SEG_5;
         5'd6:     seg_c_o = SEG_6;
         5'd7:     seg_c_o = SEG_7;
         5'd8:     seg_c_o = SEG_8;
         5'd9:     seg_c_o = SEG_9;
         GLY_A:    seg_c_o = SEG_A;
         GLY_B:    seg_c_o = SEG_B;
         GLY_C:    seg_c_o = SEG_C;
         GLY_D:    seg_c_o = SEG_D;
         GLY_E:    seg_c_o = SEG_E;
         GLY_F:    seg_c_o = SEG_F;
         GLY_U:    seg_c_o = SEG_U;
         GLY_H:    seg_c_o = SEG_H;
         GLY_L:    seg_c_o = SEG_L;
         GLY_P:    seg_c_o = SEG_P;
         GLY_DASH: seg_c_o = SEG_DASH;
         default:  seg_c_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/buaa_scroll.sv
// Message-buffer driven seven-segment display with static, scroll-left,
// scroll-right and blink modes paced by a speed-selectable prescaler.
module buaa_scroll
   import buaa_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned MSG_LEN    = 16,
   parameter int unsigned PRESCALE   = 12500000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [1:0]                  mode,
   input  logic [1:0]                  speed,
   input  logic                        load_en,
   input  logic [$clog2(MSG_LEN)-1:0]  load_addr,
   input  logic [4:0]                  load_char,
   output logic [NUM_DIGITS*7-1:0]     seg,
   output logic [$clog2(MSG_LEN)-1:0]  offset,
   output logic                        tick
);

   localparam int unsigned AW = $clog2(MSG_LEN);
   localparam int unsigned CW = $clog2(PRESCALE);
   localparam int unsigned SW = NUM_DIGITS * 7;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    mode_q, speed_q;
   logic          tick_q, tick_d;
   logic [AW-1:0] offset_q, offset_d;
   logic          phase_q, phase_d;
   logic [SW-1:0] seg_q, seg_d;
   logic [4:0]    msg_q [MSG_LEN];

   logic [31:0]   period_c;
   logic [CW-1:0] term_c;
   logic          hidden_c;

   assign period_c = PRESCALE >> speed;
   assign term_c   = CW'(period_c - 32'd1);
   // Leaving blink mode shows the message on the very next seg update.
   assign hidden_c = phase_q && (mode == MODE_BLINK);

   always_comb begin
      cnt_d    = cnt_q;
      tick_d   = 1'b0;
      offset_d = offset_q;
      phase_d  = phase_q;
      if ((mode != mode_q) || (speed != speed_q)) begin
         cnt_d = '0;
      end else if (en) begin
         if (cnt_q >= term_c) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      if (tick_d) begin
         case (mode)
            MODE_LEFT:  offset_d = (offset_q == AW'(MSG_LEN - 1)) ? '0 : offset_q + AW'(1);
            MODE_RIGHT: offset_d = (offset_q == '0) ? AW'(MSG_LEN - 1) : offset_q - AW'(1);
            MODE_BLINK: phase_d  = ~phase_q;
            default:    offset_d = offset_q;
         endcase
      end
      if (mode != MODE_BLINK) begin
         phase_d = 1'b0;
      end
   end

   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
      logic [AW-1:0] idx_c;
      logic [6:0]    pat_c;
      assign idx_c = AW'((32'(offset_q) + 32'(NUM_DIGITS - 1 - k)) % 32'(MSG_LEN));
      seg7_glyph u_glyph (
         .code_i  (msg_q[idx_c]),
         .seg_c_o (pat_c)
      );
      assign seg_d[7*k +: 7] = hidden_c ? SEG_BLANK : pat_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         mode_q   <= MODE_STATIC;
         speed_q  <= 2'b00;
         tick_q   <= 1'b0;
         offset_q <= '0;
         phase_q  <= 1'b0;
         seg_q    <= '1;
      end else begin
         cnt_q    <= cnt_d;
         mode_q   <= mode;
         speed_q  <= speed;
         tick_q   <= tick_d;
         offset_q <= offset_d;
         phase_q  <= phase_d;
         seg_q    <= seg_d;
      end
   end

   // Message buffer; reset content spells "bUAA".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(MSG_LEN); i++) begin
            msg_q[i] <= GLY_BLANK;
         end
         msg_q[0] <= GLY_B;
         msg_q[1] <= GLY_U;
         msg_q[2] <= GLY_A;
         msg_q[3] <= GLY_A;
      end else if (load_en) begin
         msg_q[load_addr] <= load_char;
      end
   end

   assign seg    = seg_q;
   assign offset = offset_q;
   assign tick   = tick_q;

endmodule
